// File: rtl/fz_pkg.sv
// -----------------------------------------------------------------------------
// fz_pkg
// Shared constants for the firing-strength normalizer:
//   - default frame geometry (rule count, data width, full-scale)
//   - divider step count and the derived per-rule cycle budget
//   - FSM state encoding (IDLE/LOAD/DIV/DONE)
// -----------------------------------------------------------------------------
package fz_pkg;

   localparam int FZ_N_RULES = 5;
   localparam int FZ_DATA_W  = 16;
   localparam int FZ_SCALE   = 1000;

   // One restoring step per cycle, plus one load cycle and one write-back cycle.
   localparam int DIV_STEPS   = 32;
   localparam int RULE_CYCLES = DIV_STEPS + 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/fz_seq_divider.sv
// -----------------------------------------------------------------------------
// fz_seq_divider
// Unsigned restoring divider, one quotient bit per cycle.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : load dividend/divisor and begin (restarts any division)
//   dividend      : DIV_W-bit unsigned numerator
//   divisor       : DIV_W-bit unsigned denominator (0 yields all-ones quotient)
//   quotient      : registered quotient
//   remainder     : registered remainder
//   done          : one-cycle pulse, DIV_W cycles after start
// -----------------------------------------------------------------------------
module fz_seq_divider
   import fz_pkg::*;
#(
   parameter int DIV_W = DIV_STEPS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic [DIV_W-1:0] quotient,
   output logic [DIV_W-1:0] remainder,
   output logic             done
);

   localparam int CNT_W = $clog2(DIV_W + 1);

   logic [DIV_W-1:0] rem_r;
   logic [DIV_W-1:0] quo_r;
   logic [DIV_W-1:0] dvs_r;
   logic [CNT_W-1:0] cnt_r;
   logic             done_r;

   // Partial remainder shifted left with the next dividend bit, and the trial difference.
   // While rem_r < dvs_r the shifted value minus the divisor always fits DIV_W bits,
   // so the top bit of the difference is a clean borrow flag.
   logic [DIV_W:0]   shift_s;
   logic [DIV_W:0]   trial_s;

   assign shift_s = {rem_r, quo_r[DIV_W-1]};
   assign trial_s = shift_s - {1'b0, dvs_r};

   // Load operands on start, then one restoring shift/subtract step per cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_r  <= '0;
         quo_r  <= '0;
         dvs_r  <= '0;
         cnt_r  <= '0;
         done_r <= 1'b0;
      end else if (start) begin
         rem_r  <= '0;
         quo_r  <= dividend;
         dvs_r  <= divisor;
         cnt_r  <= CNT_W'(DIV_W);
         done_r <= 1'b0;
      end else if (cnt_r != '0) begin
         if (trial_s[DIV_W]) begin
            rem_r <= shift_s[DIV_W-1:0];
            quo_r <= {quo_r[DIV_W-2:0], 1'b0};
         end else begin
            rem_r <= trial_s[DIV_W-1:0];
            quo_r <= {quo_r[DIV_W-2:0], 1'b1};
         end
         cnt_r  <= cnt_r - CNT_W'(1);
         done_r <= (cnt_r == CNT_W'(1));
      end else begin
         done_r <= 1'b0;
      end
   end

   assign quotient  = quo_r;
   assign remainder = rem_r;
   assign done      = done_r;

endmodule

// File: rtl/fz_normalize_top.sv
// -----------------------------------------------------------------------------
// fz_normalize_top
// Collects N_RULES firing strengths, sums them and replaces each with
// f_i * SCALE / sum (truncated) using one shared sequential divider.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : begin a frame (accepted only in IDLE or DONE)
//   in_valid  : qualifies in_data during LOAD
//   in_data   : signed firing strength, rule index = arrival order
//   busy      : high while loading or dividing
//   rd_addr   : buffer read address
//   rd_data   : buffer[rd_addr], registered, zero for addresses >= N_RULES
//   zero_sum  : last frame summed to zero
//   done      : normalized vector ready, held until the next accepted start
// -----------------------------------------------------------------------------
module fz_normalize_top
   import fz_pkg::*;
#(
   parameter int N_RULES = FZ_N_RULES,
   parameter int DATA_W  = FZ_DATA_W,
   parameter int SCALE   = FZ_SCALE,
   parameter int DIV_W   = DIV_STEPS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     busy,
   input  logic [2:0]               rd_addr,
   output logic signed [DATA_W-1:0] rd_data,
   output logic                     zero_sum,
   output logic                     done
);

   localparam int SUM_W      = DATA_W + 3;
   localparam int PH_W       = $clog2(DIV_W + 2);
   // Phase 0 loads the divider, the last phase writes the quotient back.
   localparam int PHASE_LAST = DIV_W + (RULE_CYCLES - DIV_STEPS) - 1;

   logic [1:0]        state_r;
   logic [2:0]        rule_r;
   logic [PH_W-1:0]   phase_r;
   logic [SUM_W-1:0]  sum_r;
   logic              busy_r;
   logic              done_r;
   logic              zero_sum_r;
   logic [DATA_W-1:0] rd_data_r;
   // Stores clamped strengths during LOAD, normalized values after DIV.
   logic [DATA_W-1:0] buf_r [N_RULES];

   logic [DATA_W-1:0] clamp_s;
   logic [SUM_W-1:0]  sum_next_s;
   logic              last_rule_s;
   logic              div_start_s;
   logic [DIV_W-1:0]  dividend_s;
   logic [DIV_W-1:0]  divisor_s;
   logic [DIV_W-1:0]  div_quo_s;
   logic [DIV_W-1:0]  div_rem_unused_s;
   logic              div_done_s;
   logic              rd_addr_ok_s;
   logic [DATA_W-1:0] quo_wr_s;
   logic [DIV_W-DATA_W-1:0] quo_hi_unused_s;

   // Negative strengths count as zero, both in the buffer and in the sum.
   assign clamp_s     = in_data[DATA_W-1] ? {DATA_W{1'b0}} : in_data;
   assign sum_next_s  = sum_r + SUM_W'(clamp_s);
   assign last_rule_s = (rule_r == 3'(N_RULES - 1));

   // The divider is (re)loaded on the first phase of each rule.
   assign div_start_s = (state_r == ST_DIV) && (phase_r == PH_W'(0));
   assign dividend_s  = DIV_W'(buf_r[rule_r]) * DIV_W'(SCALE);
   assign divisor_s   = DIV_W'(sum_r);

   // Quotient never exceeds SCALE, so the low DATA_W bits carry the full result.
   assign quo_wr_s        = div_quo_s[DATA_W-1:0];
   assign quo_hi_unused_s = div_quo_s[DIV_W-1:DATA_W];

   assign rd_addr_ok_s = ({29'd0, rd_addr} < 32'(N_RULES));

   fz_seq_divider #(
      .DIV_W (DIV_W)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start_s),
      .dividend  (dividend_s),
      .divisor   (divisor_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_unused_s),
      .done      (div_done_s)
   );

   // Frame control: FSM, accumulator, rule/phase counters and the vector buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         rule_r     <= '0;
         phase_r    <= '0;
         sum_r      <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         zero_sum_r <= 1'b0;
         for (int i = 0; i < N_RULES; i++) begin
            buf_r[i] <= '0;
         end
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_r    <= ST_LOAD;
                  rule_r     <= '0;
                  phase_r    <= '0;
                  sum_r      <= '0;
                  busy_r     <= 1'b1;
                  done_r     <= 1'b0;
                  zero_sum_r <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (in_valid) begin
                  buf_r[rule_r] <= clamp_s;
                  sum_r         <= sum_next_s;
                  if (last_rule_s) begin
                     rule_r  <= '0;
                     phase_r <= '0;
                     if (sum_next_s == '0) begin
                        // Nothing to normalize: publish an all-zero vector at once.
                        state_r    <= ST_DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        zero_sum_r <= 1'b1;
                        for (int i = 0; i < N_RULES; i++) begin
                           buf_r[i] <= '0;
                        end
                     end else begin
                        state_r <= ST_DIV;
                     end
                  end else begin
                     rule_r <= rule_r + 3'd1;
                  end
               end
            end
            ST_DIV: begin
               if (div_done_s) begin
                  buf_r[rule_r] <= quo_wr_s;
               end
               if (phase_r == PH_W'(PHASE_LAST)) begin
                  phase_r <= '0;
                  if (last_rule_s) begin
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     rule_r  <= '0;
                  end else begin
                     rule_r <= rule_r + 3'd1;
                  end
               end else begin
                  phase_r <= phase_r + PH_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // Registered read port; out-of-range addresses read as zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_r <= '0;
      end else if (rd_addr_ok_s) begin
         rd_data_r <= buf_r[rd_addr];
      end else begin
         rd_data_r <= '0;
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign zero_sum = zero_sum_r;
   assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_fz_normalize_top.sv
// -----------------------------------------------------------------------------
// tb_fz_normalize_top
// Directed frames with hand-computed normalized vectors, latencies and
// status flags for fz_normalize_top (defaults: 5 rules, SCALE 1000).
// -----------------------------------------------------------------------------
module tb_fz_normalize_top;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [15:0] in_data = 16'sd0;
   logic               busy;
   logic [2:0]         rd_addr = 3'd0;
   logic signed [15:0] rd_data;
   logic               zero_sum;
   logic               done;

   int checks = 0;
   int errors = 0;
   int fv[5];
   int ev[5];

   always #5 clk = ~clk;

   fz_normalize_top dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .busy     (busy),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .zero_sum (zero_sum),
      .done     (done)
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Start pulse; the next cycle must show busy and a cleared done.
   task automatic start_frame(input string tag);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val({tag, "_start_done"}, int'(done), 0);
      check_val({tag, "_start_busy"}, int'(busy), 1);
   endtask

   // Feed fv[] with 'gap' idle cycles before each value; returns on the
   // first negedge after the cycle that accepted the last value.
   task automatic feed(input int gap);
      for (int i = 0; i < 5; i++) begin
         repeat (gap) @(negedge clk);
         in_valid = 1'b1;
         in_data  = 16'(fv[i]);
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 16'sd0;
      end
   endtask

   // Count cycles (1 = cycle after last accept) until done; optionally pulse
   // start and in_valid together at cycle 'poke' to show they are ignored.
   task automatic wait_done(input string tag, input int exp_lat, input int poke);
      int n;
      n = 1;
      while (!done && n < 400) begin
         start    = (n == poke);
         in_valid = (n == poke);
         in_data  = 16'sd500;
         @(negedge clk);
         n++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 16'sd0;
      check_val({tag, "_latency"}, n, exp_lat);
   endtask

   // Sweep all 8 addresses; data appears one cycle after the address.
   task automatic check_buf(input string tag);
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a);
         @(negedge clk);
         check_val($sformatf("%s_rd%0d", tag, a), int'(rd_data), (a < 5) ? ev[a] : 0);
      end
   endtask

   task automatic run_frame(input string tag, input int gap, input int exp_lat,
                            input int exp_zero, input int poke);
      start_frame(tag);
      feed(gap);
      wait_done(tag, exp_lat, poke);
      check_val({tag, "_zero_sum"}, int'(zero_sum), exp_zero);
      check_val({tag, "_busy_done"}, int'(busy), 0);
      check_buf(tag);
   endtask

   initial begin
      // Reset state
      #3;
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_done", int'(done), 0);
      check_val("rst_zero_sum", int'(zero_sum), 0);
      check_val("rst_rd_data", int'(rd_data), 0);
      @(negedge clk);
      rst = 1'b1;

      // in_valid in IDLE must not leak into the next sum
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'sd500;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'sd0;

      fv = '{100, 200, 300, 400, 0};
      ev = '{100, 200, 300, 400, 0};
      run_frame("basic", 0, 171, 0, 0);

      // Back-to-back frames from DONE, truncating quotients
      fv = '{1, 2, 0, 0, 0};
      ev = '{333, 666, 0, 0, 0};
      run_frame("trunc3", 0, 171, 0, 0);

      fv = '{1, 1, 1, 1, 1};
      ev = '{200, 200, 200, 200, 200};
      run_frame("ones", 0, 171, 0, 0);

      fv = '{-50, 50, 0, 0, 0};
      ev = '{0, 1000, 0, 0, 0};
      run_frame("clamp", 0, 171, 0, 0);

      // Zero sum clears the buffer (previous 1000 at index 1)
      fv = '{0, 0, 0, 0, 0};
      ev = '{0, 0, 0, 0, 0};
      run_frame("zero", 0, 1, 1, 0);

      fv = '{100, 200, 300, 400, 0};
      ev = '{100, 200, 300, 400, 0};
      run_frame("stall", 3, 171, 0, 0);

      // start and in_valid pulsed mid-DIV are ignored
      run_frame("poke", 0, 171, 0, 50);

      // Asynchronous reset while dividing rule 2
      fv = '{100, 200, 300, 400, 0};
      rd_addr = 3'd1;
      start_frame("rstdiv");
      feed(0);
      repeat (79) @(negedge clk);
      check_val("rstdiv_busy_before", int'(busy), 1);
      check_val("rstdiv_rd_before", int'(rd_data), 200);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_val("rstdiv_busy", int'(busy), 0);
      check_val("rstdiv_done", int'(done), 0);
      check_val("rstdiv_rd_data", int'(rd_data), 0);
      @(negedge clk);
      rst = 1'b1;
      ev = '{0, 0, 0, 0, 0};
      check_buf("rstdiv_cleared");

      fv = '{1, 1, 1, 1, 1};
      ev = '{200, 200, 200, 200, 200};
      run_frame("after_rst", 0, 171, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
